// File: rtl/maze_wall_follower_if.sv
// Purpose: bundles the solver <-> world maze-memory port.
// Ports (master = solver side):
//   starting_row/starting_col  in  start cell, sampled once after reset
//   maze_in                    in  cell content (1=wall), valid the cycle after a maze_oe cycle
//   row/col                    out cell address
//   maze_oe/maze_we            out one-cycle read strobe / path-mark write strobe
//   done                       out exit reached
//   step_count                 out moves made, saturating
interface maze_wall_follower_if;
  logic [5:0]  starting_row;
  logic [5:0]  starting_col;
  logic        maze_in;
  logic [5:0]  row;
  logic [5:0]  col;
  logic        maze_oe;
  logic        maze_we;
  logic        done;
  logic [15:0] step_count;

  modport master (
    input  starting_row, starting_col, maze_in,
    output row, col, maze_oe, maze_we, done, step_count
  );

  modport slave (
    output starting_row, starting_col, maze_in,
    input  row, col, maze_oe, maze_we, done, step_count
  );
endinterface

// File: rtl/maze_wall_follower.sv
// Purpose: right-hand wall-follower maze solver. Walks from the start cell,
// marks every entered cell as path in the world memory and raises done on
// reaching a border cell other than the start.
// Ports:
//   clk    in  single clock, posedge
//   rst_n  in  synchronous active-low reset
//   bus    maze_wall_follower_if.master (start cell, world read/write port,
//          done, step_count); all bus outputs are registered.
// Strobe timing: maze_oe/maze_we are high during the PROBE/MARK0/MOVE cycle
// they belong to, so a read issued in PROBE is answered during EVAL.
module maze_wall_follower #(
  parameter int unsigned DIM       = 64,
  parameter int unsigned START_DIR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  maze_wall_follower_if.master bus
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 2;
  localparam int unsigned SW = 16;
  localparam logic [AW-1:0] LAST     = AW'(DIM - 1);
  localparam logic [DW-1:0] DIR_INIT = DW'(START_DIR);
  localparam logic [SW-1:0] STEP_MAX = '1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_MARK0 = 3'd1,
    S_PROBE = 3'd2,
    S_EVAL  = 3'd3,
    S_MOVE  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic          ok;
    logic [DW-1:0] dir;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
  } probe_t;

  // Candidate heading and neighbour for probe index idx (right, ahead, left, back).
  function automatic probe_t probe_fn(input logic [AW-1:0] r, input logic [AW-1:0] c,
                                      input logic [DW-1:0] d, input logic [DW-1:0] idx);
    probe_t        p;
    logic [DW-1:0] off;
    case (idx)
      2'd0:    off = 2'd1;
      2'd1:    off = 2'd0;
      2'd2:    off = 2'd3;
      default: off = 2'd2;
    endcase
    p.dir = d + off;
    p.ok  = 1'b1;
    p.row = r;
    p.col = c;
    case (p.dir)
      2'd0:    if (r == '0)   p.ok = 1'b0; else p.row = r - AW'(1);
      2'd1:    if (c == LAST) p.ok = 1'b0; else p.col = c + AW'(1);
      2'd2:    if (r == LAST) p.ok = 1'b0; else p.row = r + AW'(1);
      default: if (c == '0)   p.ok = 1'b0; else p.col = c - AW'(1);
    endcase
    return p;
  endfunction

  state_t        r_state, w_state;
  logic [AW-1:0] r_cur_row, w_cur_row, r_cur_col, w_cur_col;
  logic [AW-1:0] r_start_row, w_start_row, r_start_col, w_start_col;
  logic [DW-1:0] r_dir, w_dir, r_try_idx, w_try_idx;
  logic          r_moved, w_moved;
  logic [SW-1:0] r_step_count, w_step_count;
  logic [AW-1:0] r_row, w_row, r_col, w_col;
  logic          r_oe, w_oe, r_we, w_we, r_done, w_done;
  logic          w_enter_probe;
  logic          w_exit;
  probe_t        w_cand;
  probe_t        w_next_probe;

  // Candidate currently under test (valid in PROBE/EVAL).
  assign w_cand = probe_fn(r_cur_row, r_cur_col, r_dir, r_try_idx);

  assign w_exit = r_moved &&
                  ((r_cur_row == '0) || (r_cur_row == LAST) ||
                   (r_cur_col == '0) || (r_cur_col == LAST)) &&
                  !((r_cur_row == r_start_row) && (r_cur_col == r_start_col));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_INIT;
      r_cur_row    <= '0;
      r_cur_col    <= '0;
      r_start_row  <= '0;
      r_start_col  <= '0;
      r_dir        <= '0;
      r_try_idx    <= '0;
      r_moved      <= 1'b0;
      r_step_count <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_oe         <= 1'b0;
      r_we         <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cur_row    <= w_cur_row;
      r_cur_col    <= w_cur_col;
      r_start_row  <= w_start_row;
      r_start_col  <= w_start_col;
      r_dir        <= w_dir;
      r_try_idx    <= w_try_idx;
      r_moved      <= w_moved;
      r_step_count <= w_step_count;
      r_row        <= w_row;
      r_col        <= w_col;
      r_oe         <= w_oe;
      r_we         <= w_we;
      r_done       <= w_done;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state       = r_state;
    w_cur_row     = r_cur_row;
    w_cur_col     = r_cur_col;
    w_start_row   = r_start_row;
    w_start_col   = r_start_col;
    w_dir         = r_dir;
    w_try_idx     = r_try_idx;
    w_moved       = r_moved;
    w_step_count  = r_step_count;
    w_row         = r_row;
    w_col         = r_col;
    w_oe          = 1'b0;
    w_we          = 1'b0;
    w_done        = r_done;
    w_enter_probe = 1'b0;
    w_next_probe  = '0;

    case (r_state)
      S_INIT: begin
        w_start_row  = bus.starting_row;
        w_start_col  = bus.starting_col;
        w_cur_row    = bus.starting_row;
        w_cur_col    = bus.starting_col;
        w_dir        = DIR_INIT;
        w_moved      = 1'b0;
        w_step_count = '0;
        w_done       = 1'b0;
        w_we         = 1'b1;
        w_row        = bus.starting_row;
        w_col        = bus.starting_col;
        w_state      = S_MARK0;
      end
      S_MARK0: begin
        w_try_idx     = '0;
        w_enter_probe = 1'b1;
      end
      S_PROBE: begin
        // r_oe low means this probe was off-grid: skip it in one cycle.
        if (r_oe) begin
          w_state = S_EVAL;
        end else begin
          w_try_idx     = r_try_idx + DW'(1);
          w_enter_probe = 1'b1;
        end
      end
      S_EVAL: begin
        if (bus.maze_in) begin
          w_try_idx     = r_try_idx + DW'(1);
          w_enter_probe = 1'b1;
        end else begin
          w_cur_row    = w_cand.row;
          w_cur_col    = w_cand.col;
          w_dir        = w_cand.dir;
          w_moved      = 1'b1;
          w_step_count = (r_step_count == STEP_MAX) ? r_step_count : r_step_count + SW'(1);
          w_we         = 1'b1;
          w_row        = w_cand.row;
          w_col        = w_cand.col;
          w_state      = S_MOVE;
        end
      end
      S_MOVE: begin
        if (w_exit) begin
          w_done  = 1'b1;
          w_state = S_DONE;
        end else begin
          w_try_idx     = '0;
          w_enter_probe = 1'b1;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_state = S_INIT;
      end
    endcase

    // Set up the read for the probe about to run; off-grid probes leave the address held.
    if (w_enter_probe) begin
      w_next_probe = probe_fn(w_cur_row, w_cur_col, w_dir, w_try_idx);
      w_state      = S_PROBE;
      w_oe         = w_next_probe.ok;
      if (w_next_probe.ok) begin
        w_row = w_next_probe.row;
        w_col = w_next_probe.col;
      end
    end
  end

  assign bus.row        = r_row;
  assign bus.col        = r_col;
  assign bus.maze_oe    = r_oe;
  assign bus.maze_we    = r_we;
  assign bus.done       = r_done;
  assign bus.step_count = r_step_count;

endmodule

// File: tb/tb_maze_wall_follower.sv
// Purpose: directed bench for maze_wall_follower. Two solvers (START_DIR=1 and
// START_DIR=0) share one behavioural world memory; the unselected one is held
// in reset. The world answers a maze_oe cycle with the cell content on the
// next cycle and records every maze_we as a path mark tagged with the run id.
module tb_maze_wall_follower;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic        rst_v;
  logic        rst_n_a;
  logic        rst_n_b;
  logic [5:0]  st_row;
  logic [5:0]  st_col;
  logic        maze_in_r = 1'b1;

  int checks = 0;
  int errors = 0;
  int run_id = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  int wr0    = 0;
  int oe0    = 0;

  bit wall [64][64];
  int mark [64][64];

  maze_wall_follower_if ifa();
  maze_wall_follower_if ifb();

  assign rst_n_a = (sel == 1'b0) ? rst_v : 1'b0;
  assign rst_n_b = (sel == 1'b1) ? rst_v : 1'b0;

  assign ifa.starting_row = st_row;
  assign ifa.starting_col = st_col;
  assign ifa.maze_in      = maze_in_r;
  assign ifb.starting_row = st_row;
  assign ifb.starting_col = st_col;
  assign ifb.maze_in      = maze_in_r;

  maze_wall_follower #(.DIM(64), .START_DIR(1)) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n_a),
    .bus  (ifa.master)
  );

  maze_wall_follower #(.DIM(64), .START_DIR(0)) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n_b),
    .bus  (ifb.master)
  );

  logic        m_oe, m_we, done_v;
  logic [5:0]  m_row, m_col;
  logic [15:0] step_v;

  assign m_oe   = sel ? ifb.maze_oe    : ifa.maze_oe;
  assign m_we   = sel ? ifb.maze_we    : ifa.maze_we;
  assign m_row  = sel ? ifb.row        : ifa.row;
  assign m_col  = sel ? ifb.col        : ifa.col;
  assign done_v = sel ? ifb.done       : ifa.done;
  assign step_v = sel ? ifb.step_count : ifa.step_count;

  // World memory model
  always @(posedge clk) begin
    if (m_oe) begin
      maze_in_r <= wall[m_row][m_col];
      oe_cnt    <= oe_cnt + 1;
    end
    if (m_we) begin
      mark[m_row][m_col] <= run_id;
      wr_cnt             <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_walls();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        wall[i][j] = 1'b1;
  endtask

  function automatic int count_marks();
    int n = 0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        if (mark[i][j] == run_id) n++;
    return n;
  endfunction

  // Two reset edges, new run id, then release; the next tick is the INIT edge.
  task automatic do_reset(input logic [5:0] r, input logic [5:0] c);
    rst_v  = 1'b0;
    st_row = r;
    st_col = c;
    tick();
    run_id++;
    tick();
    wr0   = wr_cnt;
    oe0   = oe_cnt;
    rst_v = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done_v !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_step(input logic [15:0] target, input int limit);
    int n = 0;
    while (step_v !== target && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int cyc;
    int cnt;
    sel    = 1'b0;
    rst_v  = 1'b0;
    st_row = 6'd10;
    st_col = 6'd0;

    // Straight corridor on solver A (heading right)
    fill_walls();
    for (int c = 0; c < 64; c++) wall[10][c] = 1'b0;
    tick();
    run_id = 1;
    tick();
    check("rst_oe",   32'(m_oe),   32'd0);
    check("rst_we",   32'(m_we),   32'd0);
    check("rst_done", 32'(done_v), 32'd0);
    check("rst_row",  32'(m_row),  32'd0);
    check("rst_col",  32'(m_col),  32'd0);
    check("rst_step", 32'(step_v), 32'd0);
    wr0   = wr_cnt;
    rst_v = 1'b1;
    tick();
    check("corr_mark0_we",  32'(m_we),  32'd1);
    check("corr_mark0_oe",  32'(m_oe),  32'd0);
    check("corr_mark0_row", 32'(m_row), 32'd10);
    check("corr_mark0_col", 32'(m_col), 32'd0);
    wait_done(2000, cyc);
    check("corr_done",   32'(done_v), 32'd1);
    check("corr_steps",  32'(step_v), 32'd63);
    check("corr_cycles", 32'(cyc),    32'd316);
    check("corr_writes", 32'(wr_cnt - wr0), 32'd64);
    cnt = 0;
    for (int c = 0; c < 64; c++) if (mark[10][c] == run_id) cnt++;
    check("corr_cells_marked", 32'(cnt), 32'd64);
    check("corr_total_marked", 32'(count_marks()), 32'd64);
    check("corr_idle_we", 32'(m_we), 32'd0);
    check("corr_idle_oe", 32'(m_oe), 32'd0);
    repeat (3) tick();
    check("corr_done_hold", 32'(done_v), 32'd1);
    check("corr_step_hold", 32'(step_v), 32'd63);

    // Reset mid-run after 20 moves, restart from a new start column
    do_reset(6'd10, 6'd0);
    tick();
    wait_step(16'd20, 500);
    check("mr_step20", 32'(step_v), 32'd20);
    st_col = 6'd5;
    rst_v  = 1'b0;
    tick();
    check("mr_oe",   32'(m_oe),   32'd0);
    check("mr_we",   32'(m_we),   32'd0);
    check("mr_done", 32'(done_v), 32'd0);
    check("mr_row",  32'(m_row),  32'd0);
    check("mr_col",  32'(m_col),  32'd0);
    check("mr_step", 32'(step_v), 32'd0);
    rst_v = 1'b1;
    tick();
    check("mr_remark_we",  32'(m_we),  32'd1);
    check("mr_remark_row", 32'(m_row), 32'd10);
    check("mr_remark_col", 32'(m_col), 32'd5);
    wait_done(2000, cyc);
    check("mr_done_final", 32'(done_v), 32'd1);
    check("mr_steps",      32'(step_v), 32'd58);

    // Right-turn priority on solver B (heading up)
    sel = 1'b1;
    fill_walls();
    wall[5][5] = 1'b0;
    wall[5][6] = 1'b0;
    wall[4][5] = 1'b0;
    do_reset(6'd5, 6'd5);
    tick();
    check("rt_mark0_we", 32'(m_we), 32'd1);
    tick();
    check("rt_probe_oe",  32'(m_oe),  32'd1);
    check("rt_probe_row", 32'(m_row), 32'd5);
    check("rt_probe_col", 32'(m_col), 32'd6);
    tick();
    tick();
    check("rt_move_we",   32'(m_we),   32'd1);
    check("rt_move_row",  32'(m_row),  32'd5);
    check("rt_move_col",  32'(m_col),  32'd6);
    check("rt_move_step", 32'(step_v), 32'd1);
    tick();
    // Heading right now, so the first probe is downward
    check("rt_next_oe",  32'(m_oe),  32'd1);
    check("rt_next_row", 32'(m_row), 32'd6);
    check("rt_next_col", 32'(m_col), 32'd6);

    // Dead-end pocket off a vertical corridor
    fill_walls();
    for (int r = 0; r <= 30; r++) wall[r][10] = 1'b0;
    wall[25][11] = 1'b0;
    wall[25][12] = 1'b0;
    wall[25][13] = 1'b0;
    do_reset(6'd30, 6'd10);
    wait_done(3000, cyc);
    check("de_done",    32'(done_v), 32'd1);
    check("de_steps",   32'(step_v), 32'd36);
    check("de_writes",  32'(wr_cnt - wr0), 32'd37);
    check("de_distinct", 32'(count_marks()), 32'd34);
    check("de_pocket_end", 32'(mark[25][13] == run_id), 32'd1);
    check("de_exit_row0",  32'(mark[0][10] == run_id),  32'd1);

    // Corner start: up and left are skipped without reads
    fill_walls();
    wall[0][0] = 1'b0;
    wall[1][0] = 1'b0;
    do_reset(6'd0, 6'd0);
    tick();
    wait_done(100, cyc);
    check("cor_done",   32'(done_v), 32'd1);
    check("cor_steps",  32'(step_v), 32'd1);
    check("cor_cycles", 32'(cyc),    32'd8);
    check("cor_reads",  32'(oe_cnt - oe0), 32'd2);
    check("cor_writes", 32'(wr_cnt - wr0), 32'd2);
    check("cor_mark10", 32'(mark[1][0] == run_id), 32'd1);

    // Border start revisited: passing back through the start is not an exit
    fill_walls();
    wall[0][7] = 1'b0;
    wall[1][7] = 1'b0;
    wall[2][7] = 1'b0;
    do_reset(6'd0, 6'd7);
    tick();
    wait_step(16'd4, 200);
    check("bs_step4",     32'(step_v), 32'd4);
    check("bs_revisit_we", 32'(m_we),  32'd1);
    check("bs_revisit_row", 32'(m_row), 32'd0);
    check("bs_revisit_col", 32'(m_col), 32'd7);
    repeat (60) tick();
    check("bs_no_done",    32'(done_v), 32'd0);
    check("bs_still_moving", 32'(step_v > 16'd4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
